// File: rtl/ifu_fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
//   state_e        : 2-bit FSM encoding (BOOT/REQ/WAIT/HOLD)
//   *_DEF          : default PC width, reset PC and NOP instruction
//   resp_is_fault  : classifies an AXI-lite read response
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam int unsigned DATA_LEN_DEF = 32;
  localparam logic [31:0] RST_PC_DEF   = 32'h8000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [1:0]  RESP_OKAY    = 2'b00;

  // Any response other than OKAY is treated as a fetch fault.
  function automatic logic resp_is_fault(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage. Holds the PC, issues one AXI-lite read per
// instruction (at most one outstanding) and hands {inst, PC} to decode over
// a valid/ready handshake. Execute can redirect the PC with jump_valid/jump_pc.
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   araddr/arvalid/arready       : read address channel
//   rdata/rresp/rvalid/rready    : read data channel
//   inst/PC/inst_valid/inst_ready: instruction to decode
//   inst_fault                   : held inst came from a non-OKAY response
//   jump_valid/jump_pc           : redirect request from execute
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned          DATA_LEN = DATA_LEN_DEF,
  parameter logic [DATA_LEN-1:0]  RST_PC   = RST_PC_DEF,
  parameter logic [31:0]          NOP_INST = NOP_INST_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [DATA_LEN-1:0] araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [31:0]         inst,
  output logic [DATA_LEN-1:0] PC,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic                inst_fault,
  input  logic                jump_valid,
  input  logic [DATA_LEN-1:0] jump_pc
);

  state_e              state_q, state_d;
  logic [DATA_LEN-1:0] pc_q, pc_d;
  logic [31:0]         inst_q, inst_d;
  logic                fault_q, fault_d;
  logic                redir_q, redir_d;
  logic [DATA_LEN-1:0] redir_pc_q, redir_pc_d;
  logic [DATA_LEN-1:0] target_s;

  // A jump arriving this cycle overrides any pending redirect.
  assign target_s = jump_valid ? jump_pc : redir_pc_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RST_PC;
      inst_q     <= NOP_INST;
      fault_q    <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= {DATA_LEN{1'b0}};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      fault_q    <= fault_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        if (arready) state_d = ST_WAIT;
        else         state_d = ST_REQ;
      end
      ST_WAIT: begin
        if (rvalid) state_d = (redir_q || jump_valid) ? ST_REQ : ST_HOLD;
        else        state_d = ST_WAIT;
      end
      ST_HOLD: begin
        // Redirect beats the handshake; both leave HOLD.
        if (jump_valid || inst_ready) state_d = ST_REQ;
        else                          state_d = ST_HOLD;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Next-PC mux, instruction latch and redirect bookkeeping.
  always_comb begin
    pc_d       = pc_q;
    inst_d     = inst_q;
    fault_d    = fault_q;
    redir_d    = redir_q;
    redir_pc_d = redir_pc_q;
    case (state_q)
      ST_BOOT: begin
        if (jump_valid) pc_d = jump_pc;
        else            pc_d = pc_q;
      end
      ST_REQ: begin
        // The request is never withdrawn; remember the jump for later.
        if (jump_valid) begin
          redir_d    = 1'b1;
          redir_pc_d = jump_pc;
        end else begin
          redir_d    = redir_q;
        end
      end
      ST_WAIT: begin
        if (rvalid) begin
          if (redir_q || jump_valid) begin
            pc_d    = target_s;
            redir_d = 1'b0;
          end else begin
            inst_d  = resp_is_fault(rresp) ? NOP_INST : rdata;
            fault_d = resp_is_fault(rresp);
          end
        end else if (jump_valid) begin
          redir_d    = 1'b1;
          redir_pc_d = jump_pc;
        end else begin
          redir_d    = redir_q;
        end
      end
      ST_HOLD: begin
        if (jump_valid)      pc_d = jump_pc;
        else if (inst_ready) pc_d = pc_q + DATA_LEN'(32'd4);
        else                 pc_d = pc_q;
      end
      default: pc_d = pc_q;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    arvalid    = 1'b0;
    rready     = 1'b0;
    inst_valid = 1'b0;
    case (state_q)
      ST_REQ:  arvalid    = 1'b1;
      ST_WAIT: rready     = 1'b1;
      ST_HOLD: inst_valid = 1'b1;
      default: begin
        arvalid    = 1'b0;
        rready     = 1'b0;
        inst_valid = 1'b0;
      end
    endcase
  end

  assign araddr     = pc_q;
  assign PC         = pc_q;
  assign inst       = inst_q;
  assign inst_fault = fault_q;

endmodule
